// File: rtl/mac_pkg.sv
// Shared definitions for the saturating multiply-accumulate block.
// Holds the FSM state encoding and the default parameter widths.
// No logic; imported by mac_acc and sat_add.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int IN_SIZE_DEF  = 16;
    localparam int ACC_SIZE_DEF = 24;
    localparam int CNT_SIZE_DEF = 8;

endpackage

// File: rtl/mac_acc_sat_add.sv
// Unsigned saturating adder: sum = min(a + b, 2^acc_size - 1).
// Latency: combinational.
// Backpressure: none; pure function of its operands.
module sat_add
    import mac_pkg::*;
#(
    parameter int acc_size = ACC_SIZE_DEF
) (
    input  logic [acc_size-1:0] a,
    input  logic [acc_size-1:0] b,
    output logic [acc_size-1:0] sum,
    output logic                ovf
);

    logic [acc_size:0] w_full;

    // One extra bit catches the carry out; a carry means the true sum is out of range.
    assign w_full = {1'b0, a} + {1'b0, b};
    assign ovf    = w_full[acc_size];
    assign sum    = ovf ? {acc_size{1'b1}} : w_full[acc_size-1:0];

endmodule

// File: rtl/mac_acc.sv
// Accumulates len unsigned samples with saturation, then presents one result.
// Latency: out_valid rises the cycle after the last sample is accepted.
// Backpressure: in_ready only in ACC; result held in DONE until out_ready.
module mac_acc
    import mac_pkg::*;
#(
    parameter int in_size  = IN_SIZE_DEF,
    parameter int acc_size = ACC_SIZE_DEF,
    parameter int cnt_size = CNT_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [cnt_size-1:0] len,
    input  logic                in_valid,
    input  logic [in_size-1:0]  in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [acc_size-1:0] out_data,
    output logic                out_sat,
    input  logic                out_ready,
    output logic                busy
);

    // Samples wider than the accumulator saturate on their own.
    localparam int EXT = (in_size > acc_size) ? in_size : acc_size;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [acc_size-1:0] r_sum;
    logic                r_sat;
    logic [cnt_size-1:0] r_cnt;
    logic [cnt_size-1:0] r_len;

    logic                w_start_blk;
    logic                w_accept;
    logic                w_last;
    logic [EXT-1:0]      w_data_ext;
    logic                w_data_big;
    logic [acc_size-1:0] w_b;
    logic [acc_size-1:0] w_sum;
    logic                w_add_ovf;
    logic                w_ovf;

    assign w_start_blk = (r_state == ST_IDLE) && start;
    assign w_accept    = (r_state == ST_ACC) && in_valid;
    // Compare against len-1 so the counter never has to reach len (no wrap at len=2^cnt_size-1).
    assign w_last      = w_accept && (r_cnt == r_len - 1'b1);

    assign w_data_ext  = EXT'(in_data);
    assign w_data_big  = (EXT > acc_size) ? (|(w_data_ext >> acc_size)) : 1'b0;
    assign w_b         = w_data_big ? {acc_size{1'b1}} : w_data_ext[acc_size-1:0];
    assign w_ovf       = w_add_ovf | w_data_big;

    sat_add #(
        .acc_size (acc_size)
    ) u_sat_add (
        .a   (r_sum),
        .b   (w_b),
        .sum (w_sum),
        .ovf (w_add_ovf)
    );

    // Next-state: IDLE -> ACC (or straight to DONE for an empty block) -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Running sum and sticky saturation flag; cleared on every accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_sat <= 1'b0;
        end else if (w_start_blk) begin
            r_sum <= '0;
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sum <= w_sum;
            r_sat <= r_sat | w_ovf;
        end
    end

    // Block length capture and accepted-sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_start_blk) begin
            r_len <= len;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_sum;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_mac_acc.sv
// Bench for mac_acc: a default (24-bit) and a 16-bit accumulator share stimulus.
// Table vectors cover the directed cases; random blocks use an arithmetic model.
// All waits are fixed cycle counts, so the run always terminates.
module tb_mac_acc;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready,  in_ready16;
    logic        out_valid, out_valid16;
    logic [23:0] out_data;
    logic [15:0] out_data16;
    logic        out_sat,   out_sat16;
    logic        busy,      busy16;

    int checks = 0;
    int errors = 0;
    int q[$];

    mac_acc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
        .out_ready(out_ready), .busy(busy)
    );

    mac_acc #(.acc_size(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready16),
        .out_valid(out_valid16), .out_data(out_data16), .out_sat(out_sat16),
        .out_ready(out_ready), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       n;
        logic [3:0]       gap;
        logic [3:0]       ordly;
        logic             poke;
        logic [3:0][15:0] s;
        logic [31:0]      e24;
        logic             s24;
        logic [31:0]      e16;
        logic             s16;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result from plain arithmetic: running sum clamped to the width's maximum.
    function automatic void model(input int w, output longint sum, output bit sat);
        longint mx;
        mx  = (longint'(1) << w) - 1;
        sum = 0;
        sat = 1'b0;
        foreach (q[i]) begin
            sum = sum + q[i];
            if (sum > mx) begin
                sum = mx;
                sat = 1'b1;
            end
        end
    endfunction

    task automatic check_result(input string tag, input longint e24, input bit s24,
                                input longint e16, input bit s16);
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " out_valid16"}, out_valid16, 1);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " out_data24"}, out_data, e24);
        chk({tag, " out_sat24"}, out_sat, s24);
        chk({tag, " out_data16"}, out_data16, e16);
        chk({tag, " out_sat16"}, out_sat16, s16);
    endtask

    // Drives one complete block from start to output handshake, with junk on idle inputs.
    task automatic run_block(input string tag, input int n, input int gap, input int ordly,
                             input bit poke, input longint e24, input bit s24,
                             input longint e16, input bit s16);
        start = 1'b1;
        len   = 8'(n);
        step();
        start = 1'b0;
        len   = 8'($urandom);
        chk({tag, " busy after start"}, busy, 1);
        if (n == 0) begin
            chk({tag, " empty done"}, out_valid, 1);
        end else begin
            chk({tag, " acc out_valid"}, out_valid, 0);
            for (int i = 0; i < n; i++) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    start    = poke;
                    len      = 8'($urandom);
                    step();
                    chk({tag, " stall in_ready"}, in_ready, 1);
                    chk({tag, " stall out_valid"}, out_valid, 0);
                end
                in_valid = 1'b1;
                in_data  = 16'(q[i]);
                start    = poke;
                step();
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                start    = 1'b0;
                if (i < n - 1) begin
                    chk({tag, " mid in_ready"}, in_ready, 1);
                end
            end
        end
        check_result(tag, e24, s24, e16, s16);
        for (int d = 0; d < ordly; d++) begin
            out_ready = 1'b0;
            start     = poke;
            in_valid  = 1'b1;
            in_data   = 16'($urandom);
            step();
            check_result({tag, " hold"}, e24, s24, e16, s16);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd5;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk({tag, " out_valid after hs"}, out_valid, 0);
        chk({tag, " busy after hs"}, busy, 0);
        step();
        chk({tag, " start ignored at hs"}, busy, 0);
    endtask

    initial begin
        longint m24, m16;
        bit     t24, t16;
        int     n;

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;

        vt[0] = '{n:8'd4,   gap:4'd0, ordly:4'd0, poke:1'b0,
                  s:{16'd400, 16'd300, 16'd200, 16'd100},
                  e24:32'd1000, s24:1'b0, e16:32'd1000, s16:1'b0};
        vt[1] = '{n:8'd3,   gap:4'd0, ordly:4'd0, poke:1'b0,
                  s:{16'd65535, 16'd65535, 16'd65535, 16'd65535},
                  e24:32'd196605, s24:1'b0, e16:32'd65535, s16:1'b1};
        vt[2] = '{n:8'd0,   gap:4'd0, ordly:4'd1, poke:1'b0,
                  s:{16'd9, 16'd9, 16'd9, 16'd9},
                  e24:32'd0, s24:1'b0, e16:32'd0, s16:1'b0};
        vt[3] = '{n:8'd4,   gap:4'd3, ordly:4'd5, poke:1'b1,
                  s:{16'd40, 16'd30, 16'd20, 16'd10},
                  e24:32'd100, s24:1'b0, e16:32'd100, s16:1'b0};
        vt[4] = '{n:8'd2,   gap:4'd0, ordly:4'd0, poke:1'b0,
                  s:{16'd0, 16'd0, 16'd8, 16'd7},
                  e24:32'd15, s24:1'b0, e16:32'd15, s16:1'b0};
        vt[5] = '{n:8'd255, gap:4'd0, ordly:4'd0, poke:1'b0,
                  s:{16'd1, 16'd1, 16'd1, 16'd1},
                  e24:32'd255, s24:1'b0, e16:32'd255, s16:1'b0};

        #3;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_sat", out_sat, 0);
        #9;
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            if (v == 4) begin
                // Abort a block halfway with reset, then start fresh straight after release.
                step();
                start = 1'b1; len = 8'd4;
                step();
                start = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    in_valid = 1'b1; in_data = 16'd1000;
                    step();
                end
                in_valid = 1'b0;
                rst_n = 1'b0;
                #2;
                chk("midrst busy", busy, 0);
                chk("midrst in_ready", in_ready, 0);
                chk("midrst out_valid", out_valid, 0);
                chk("midrst out_data", out_data, 0);
                chk("midrst out_sat", out_sat, 0);
                #2;
                rst_n = 1'b1;
            end
            q.delete();
            for (int i = 0; i < int'(vt[v].n); i++) q.push_back(int'(vt[v].s[i % 4]));
            run_block($sformatf("vec%0d", v), int'(vt[v].n), int'(vt[v].gap),
                      int'(vt[v].ordly), vt[v].poke, longint'(vt[v].e24), vt[v].s24,
                      longint'(vt[v].e16), vt[v].s16);
        end

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 40);
            q.delete();
            for (int i = 0; i < n; i++) begin
                q.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(60000, 65535))
                                                        : int'($urandom_range(0, 300)));
            end
            model(24, m24, t24);
            model(16, m16, t16);
            run_block($sformatf("rnd%0d", r), n, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), m24, t24, m16, t16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_acc.md
MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 Parameter in_size, default 16, SHALL set the width of each unsigned input sample (one MAC product).
REQ-002 Parameter acc_size, default 24, SHALL set the width of the accumulated result.
REQ-003 Parameter cnt_size, default 8, SHALL set the width of the block-length input.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL request a new accumulation, sampled only in IDLE.
REQ-007 len  input  cnt_size  SHALL give the sample count, captured with start.
REQ-008 in_valid  input  1  SHALL mark in_data valid.
REQ-009 in_data  input  in_size  SHALL carry an unsigned MAC product.
REQ-010 in_ready  output  1  SHALL indicate the block accepts a sample this cycle.
REQ-011 out_valid  output  1  SHALL indicate out_data/out_sat hold a final result.
REQ-012 out_data  output  acc_size  SHALL carry the accumulated sum.
REQ-013 out_sat  output  1  SHALL flag that saturation occurred during this block.
REQ-014 out_ready  input  1  SHALL indicate the consumer takes the result.
REQ-015 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-016 FSM SHALL have states IDLE, ACC, DONE.
REQ-017 IDLE: start=1 with len!=0 SHALL capture len, clear sum, counter and sticky flag, and go to ACC next cycle.
REQ-018 IDLE: start=1 with len=0 SHALL go to DONE with sum=0, out_sat=0.
REQ-019 in_ready SHALL be 1 only in ACC; a sample is accepted when in_valid&&in_ready.
REQ-020 Each accepted sample SHALL be zero-extended and added to sum; a result above 2^acc_size-1 SHALL clamp to 2^acc_size-1 and set the sticky flag.
REQ-021 Once the sum is clamped, further samples SHALL leave it at 2^acc_size-1.
REQ-022 Acceptance of sample number len SHALL move the FSM to DONE; out_valid SHALL rise the cycle after the last accept.
REQ-023 in_valid low in ACC SHALL stall the block: no count change and no timeout.
REQ-024 DONE: out_valid=1 and out_data/out_sat SHALL hold stable until out_valid&&out_ready.
REQ-025 Output handshake SHALL return the FSM to IDLE next cycle; back-to-back throughput is one block per len+2 cycles minimum.
REQ-026 start SHALL be ignored outside IDLE, including the cycle the output handshake completes.
REQ-027 len and in_data changes outside their capture and accept cycles SHALL have no effect.
REQ-028 The counter SHALL be cnt_size bits; len=2^cnt_size-1 SHALL be supported without wrap.

Reset
REQ-029 While rst_n=0: state=IDLE; sum, counter, captured len and sticky flag SHALL be 0.
REQ-030 While rst_n=0: in_ready, out_valid, out_sat and busy SHALL be 0, and out_data SHALL be 0.
REQ-031 Reset mid-block SHALL discard the partial sum; no out_valid SHALL follow release.
REQ-032 After rst_n deasserts, the first start SHALL be honoured at the first rising edge.

Structure
REQ-033 State encodings (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and default widths SHALL live in shared package mac_pkg.
REQ-034 The saturating adder SHALL be a sub-module sat_add (parameter acc_size, combinational): operands a and b, outputs sum and ovf.
REQ-035 Block SHALL be synthesizable, with no latches and one always block per register group.

Verification
REQ-036 start, len=4; samples 100,200,300,400; out_ready=1 -> out_data=1000, out_sat=0; out_valid one cycle after the 4th accept.
REQ-037 len=3, acc_size=24, samples 65535 x3 -> out_data=196605, out_sat=0; then force acc_size=16 build -> out_data=65535, out_sat=1.
REQ-038 start with len=0 -> DONE next cycle; out_data=0; in_ready never asserted.
REQ-039 len=4; in_valid gaps of 3 cycles between samples; out_ready held low 5 cycles -> out_data stable and out_valid high throughout; start pulses during ACC/DONE ignored.
REQ-040 rst_n low after 2 of 4 samples, then new start len=2 with samples 7,8 -> out_data=15, with no stale result.
REQ-041 len=255 of sample 1 -> out_data=255; counter does not wrap; busy falls one cycle after the handshake.
